// File: rtl/execute_unit_mc.sv
// execute_unit_mc: registered RV32I/RV64I execute stage, valid/ready in and out.
// Define EXEC_MULDIV_EN to build the M extension (multiplier + iterative divider).
module execute_unit_mc #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] valA,
    input  logic [XLEN-1:0] valB,
    input  logic [XLEN-1:0] valC,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] valE,
    output logic            cond,
    output logic            busy
);
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;

    logic               accept;
    logic               is_op;
    logic               is_m;
    logic [XLEN-1:0]    opb;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    sra;
    logic               lt_s;
    logic               lt_u;
    logic               br_lts;
    logic               br_ltu;
    logic [XLEN-1:0]    res;
    logic               res_cond;
    logic               start_div;
    logic               div_out;
    logic [XLEN-1:0]    div_res;

    assign accept   = in_valid && in_ready;
    assign in_ready = !busy && (!out_valid || out_ready);
    assign is_op    = opcode == OPC_OP;
    assign is_m     = is_op && (func7 == 7'b0000001);
    assign opb      = is_op ? valB : valC;
    assign shamt    = opb[SHAMT_W-1:0];
    assign sra      = $signed(valA) >>> shamt;
    assign lt_s     = $signed(valA) < $signed(opb);
    assign lt_u     = valA < opb;
    assign br_lts   = $signed(valA) < $signed(valB);
    assign br_ltu   = valA < valB;

`ifdef EXEC_MULDIV_EN
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] mul_p;
    logic              div_op;
    logic              div_sgn;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   spec_res;

    assign mul_a = (func3[1:0] != 2'b11) ?
                   {{XLEN{valA[XLEN-1]}}, valA} : {{XLEN{1'b0}}, valA};
    assign mul_b = (func3[1:0] == 2'b01) ?
                   {{XLEN{valB[XLEN-1]}}, valB} : {{XLEN{1'b0}}, valB};
    assign mul_p = mul_a * mul_b;

    assign div_op   = is_m && func3[2];
    assign div_sgn  = !func3[0];
    assign div_zero = valB == '0;
    assign div_ovf  = div_sgn && (valB == '1) &&
                      (valA == {1'b1, {(XLEN-1){1'b0}}});
    assign spec_res = func3[1] ? (div_zero ? valA : '0)
                               : (div_zero ? '1 : valA);
    assign start_div = accept && div_op && !div_zero && !div_ovf && !flush;
`endif

    // single-cycle result and branch condition
    always_comb begin
        res      = '0;
        res_cond = 1'b0;
        unique case (opcode)
            OPC_OP, OPC_IMM: begin
                if (is_m) begin
`ifdef EXEC_MULDIV_EN
                    if (func3[2])
                        res = spec_res;
                    else if (func3[1:0] == 2'b00)
                        res = mul_p[XLEN-1:0];
                    else
                        res = mul_p[2*XLEN-1:XLEN];
`else
                    res = '0;
`endif
                end else begin
                    unique case (func3)
                        3'b000: res = (is_op && func7[5]) ? valA - opb : valA + opb;
                        3'b001: res = valA << shamt;
                        3'b010: res = {{(XLEN-1){1'b0}}, lt_s};
                        3'b011: res = {{(XLEN-1){1'b0}}, lt_u};
                        3'b100: res = valA ^ opb;
                        3'b101: res = func7[5] ? sra : valA >> shamt;
                        3'b110: res = valA | opb;
                        default: res = valA & opb;
                    endcase
                end
            end
            OPC_LOAD, OPC_STORE: res = valA + valC;
            OPC_LUI:             res = valC;
            OPC_AUIPC:           res = pc + valC;
            OPC_JAL, OPC_JALR: begin
                res      = pc + {{(XLEN-3){1'b0}}, 3'b100};
                res_cond = 1'b1;
            end
            OPC_BR: begin
                res = pc + valC;
                unique case (func3)
                    3'b000:  res_cond = valA == valB;
                    3'b001:  res_cond = valA != valB;
                    3'b100:  res_cond = br_lts;
                    3'b101:  res_cond = !br_lts;
                    3'b110:  res_cond = br_ltu;
                    3'b111:  res_cond = !br_ltu;
                    default: res_cond = 1'b0;
                endcase
            end
            default: begin
                res      = '0;
                res_cond = 1'b0;
            end
        endcase
    end

`ifdef EXEC_MULDIV_EN
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [SHAMT_W:0] cnt_q;
    logic            neg_q;
    logic            neg_r;
    logic            want_rem;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN:0]   shf;
    logic [XLEN:0]   dif;

    assign abs_a   = (div_sgn && valA[XLEN-1]) ? -valA : valA;
    assign abs_b   = (div_sgn && valB[XLEN-1]) ? -valB : valB;
    assign shf     = {rem_q, quo_q[XLEN-1]};
    assign dif     = shf - {1'b0, dvs_q};
    assign busy    = state != IDLE;
    assign div_out = (state == DONE) && (!out_valid || out_ready) && !flush;
    assign div_res = want_rem ? (neg_r ? -rem_q : rem_q)
                              : (neg_q ? -quo_q : quo_q);

    // divider next state; flush always returns to IDLE
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start_div) state_nx = ITER;
            ITER: if (cnt_q == {{SHAMT_W{1'b0}}, 1'b1}) state_nx = DONE;
            DONE: if (div_out) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // divider state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // restoring divide on magnitudes, one quotient bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            want_rem <= 1'b0;
        end else if (start_div) begin
            rem_q    <= '0;
            quo_q    <= abs_a;
            dvs_q    <= abs_b;
            cnt_q    <= (SHAMT_W+1)'(XLEN);
            neg_q    <= div_sgn && (valA[XLEN-1] ^ valB[XLEN-1]);
            neg_r    <= div_sgn && valA[XLEN-1];
            want_rem <= func3[1];
        end else if (state == ITER) begin
            cnt_q <= cnt_q - 1'b1;
            if (!dif[XLEN]) begin
                rem_q <= dif[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shf[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end
`else
    assign busy      = 1'b0;
    assign start_div = 1'b0;
    assign div_out   = 1'b0;
    assign div_res   = '0;
`endif

    // output register: flush wins, then divider completion, then 1-cycle ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            valE      <= '0;
            cond      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            valE      <= '0;
            cond      <= 1'b0;
        end else if (div_out) begin
            out_valid <= 1'b1;
            valE      <= div_res;
            cond      <= 1'b0;
        end else if (accept && !start_div) begin
            out_valid <= 1'b1;
            valE      <= res;
            cond      <= res_cond;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_execute_unit_mc.sv
// tb_execute_unit_mc: directed vectors with a queue scoreboard and
// an independent output monitor for execute_unit_mc (XLEN = 32).
module tb_execute_unit_mc;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] IMM   = 7'b0010011;
    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] F7A   = 7'b0100000;
    localparam logic [6:0] F7M   = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] valA, valB, valC, pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] valE;
    logic        cond;
    logic        busy;

    typedef struct {
        logic [31:0] e;
        logic        c;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    execute_unit_mc #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func3(func3), .func7(func7),
        .valA(valA), .valB(valB), .valC(valC), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .valE(valE), .cond(cond), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: samples just after the falling edge, after drivers settle
    always @(negedge clk) begin
        exp_t x;
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got valE %h, none expected", valE);
            end else begin
                x = sb.pop_front();
                chk($sformatf("valE@%0d", x.acc), valE, x.e);
                chk($sformatf("cond@%0d", x.acc), {31'd0, cond}, {31'd0, x.c});
                if (x.lat >= 0)
                    chk($sformatf("latency@%0d", x.acc), cyc - x.acc, x.lat);
            end
        end
    end

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] p, input logic [31:0] e,
                         input logic cd, input int lat, input bit push);
        int n;
        exp_t x;
        @(negedge clk);
        opcode = op; func3 = f3; func7 = f7;
        valA = a; valB = b; valC = c; pc = p;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready %b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        x.e = e; x.c = cd; x.lat = lat; x.acc = cyc + 1;
        if (push) sb.push_back(x);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit saw;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; func3 = '0; func7 = '0;
        valA = '0; valB = '0; valC = '0; pc = '0;

        // ADD offered while reset is held: nothing may come out
        @(negedge clk);
        opcode = OP; valA = 32'd5; valB = 32'd7; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_valE", valE, 32'd0);
        chk("rst_cond", {31'd0, cond}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // back-to-back single-cycle ops
        issue(OP,    3'b000, 7'd0, 32'd5,        32'd7,  32'd0,        32'd0,        32'd12,       1'b0, 0, 1);
        issue(OP,    3'b000, F7A,  32'd5,        32'd7,  32'd0,        32'd0,        32'hFFFFFFFE, 1'b0, 0, 1);
        issue(OP,    3'b000, 7'd0, 32'hFFFFFFFF, 32'd1,  32'd0,        32'd0,        32'd0,        1'b0, 0, 1);
        issue(OP,    3'b001, 7'd0, 32'd1,        32'd36, 32'd0,        32'd0,        32'h10,       1'b0, 0, 1);
        issue(OP,    3'b010, 7'd0, 32'hFFFFFFFF, 32'd1,  32'd0,        32'd0,        32'd1,        1'b0, 0, 1);
        issue(OP,    3'b011, 7'd0, 32'hFFFFFFFF, 32'd1,  32'd0,        32'd0,        32'd0,        1'b0, 0, 1);
        issue(OP,    3'b100, 7'd0, 32'hF0F0,     32'h0FF0, 32'd0,      32'd0,        32'hFF00,     1'b0, 0, 1);
        issue(OP,    3'b101, 7'd0, 32'h80000000, 32'd4,  32'd0,        32'd0,        32'h08000000, 1'b0, 0, 1);
        issue(OP,    3'b101, F7A,  32'h80000000, 32'd4,  32'd0,        32'd0,        32'hF8000000, 1'b0, 0, 1);
        issue(OP,    3'b110, 7'd0, 32'hA0,       32'h0B, 32'd0,        32'd0,        32'hAB,       1'b0, 0, 1);
        issue(OP,    3'b111, 7'd0, 32'hF0F0,     32'h0FF0, 32'd0,      32'd0,        32'h00F0,     1'b0, 0, 1);
        issue(IMM,   3'b000, 7'd0, 32'd10,       32'd99, 32'hFFFFFFFD, 32'd0,        32'd7,        1'b0, 0, 1);
        issue(IMM,   3'b101, F7A,  32'h80000000, 32'd0,  32'h404,      32'd0,        32'hF8000000, 1'b0, 0, 1);
        issue(IMM,   3'b010, 7'd0, 32'hFFFFFFFB, 32'd0,  32'hFFFFFFFD, 32'd0,        32'd1,        1'b0, 0, 1);
        issue(LOAD,  3'b010, 7'd0, 32'h1000,     32'd0,  32'hFFFFFFFC, 32'd0,        32'hFFC,      1'b0, 0, 1);
        issue(STORE, 3'b010, 7'd0, 32'h2000,     32'd5,  32'd8,        32'd0,        32'h2008,     1'b0, 0, 1);
        issue(LUI,   3'b000, 7'd0, 32'd3,        32'd0,  32'h12345000, 32'h40,       32'h12345000, 1'b0, 0, 1);
        issue(AUIPC, 3'b000, 7'd0, 32'd3,        32'd0,  32'h1000,     32'h400,      32'h1400,     1'b0, 0, 1);
        issue(JAL,   3'b000, 7'd0, 32'd0,        32'd0,  32'h40,       32'h80,       32'h84,       1'b1, 0, 1);
        issue(JALR,  3'b000, 7'd0, 32'd9,        32'd0,  32'd0,        32'hFFFFFFFC, 32'd0,        1'b1, 0, 1);
        issue(BR,    3'b000, 7'd0, 32'd3,        32'd3,  32'h20,       32'h100,      32'h120,      1'b1, 0, 1);
        issue(BR,    3'b001, 7'd0, 32'd3,        32'd3,  32'h20,       32'h100,      32'h120,      1'b0, 0, 1);
        issue(BR,    3'b100, 7'd0, 32'hFFFFFFFF, 32'd1,  32'h20,       32'h100,      32'h120,      1'b1, 0, 1);
        issue(BR,    3'b110, 7'd0, 32'hFFFFFFFF, 32'd1,  32'h20,       32'h100,      32'h120,      1'b0, 0, 1);
        issue(BR,    3'b101, 7'd0, 32'hFFFFFFFF, 32'd1,  32'h20,       32'h100,      32'h120,      1'b0, 0, 1);
        issue(BR,    3'b111, 7'd0, 32'hFFFFFFFF, 32'd1,  32'h20,       32'h100,      32'h120,      1'b1, 0, 1);
        issue(BR,    3'b010, 7'd0, 32'd1,        32'd1,  32'h20,       32'h100,      32'h120,      1'b0, 0, 1);
        issue(7'h7F, 3'b000, 7'd0, 32'd5,        32'd7,  32'd9,        32'h100,      32'd0,        1'b0, 0, 1);
        drain();

        // SLLI result held with out_ready low for three cycles
        out_ready = 1'b0;
        issue(IMM, 3'b001, 7'd0, 32'd1, 32'd0, 32'd33, 32'd0, 32'd2, 1'b0, -1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("hold_valE_%0d", i), valE, 32'd2);
            chk($sformatf("hold_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        // flush in the accept cycle discards the op
        @(negedge clk);
        opcode = OP; func3 = 3'b000; func7 = 7'd0;
        valA = 32'd1; valB = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_accept_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_accept_ready", {31'd0, in_ready}, 32'd1);

        // flush kills a result parked in the output register
        out_ready = 1'b0;
        issue(OP, 3'b000, 7'd0, 32'd4, 32'd4, 32'd0, 32'd0, 32'd8, 1'b0, 0, 0);
        @(negedge clk);
        chk("parked_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_parked_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);

`ifdef EXEC_MULDIV_EN
        issue(OP, 3'b000, F7M, 32'd3,        32'hFFFFFFFC, 32'd0, 32'd0, 32'hFFFFFFF4, 1'b0, 0, 1);
        issue(OP, 3'b001, F7M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0,        1'b0, 0, 1);
        issue(OP, 3'b011, F7M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFE, 1'b0, 0, 1);
        issue(OP, 3'b010, F7M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 0, 1);
        issue(OP, 3'b100, F7M, 32'd7,        32'd0,        32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 0, 1);
        issue(OP, 3'b110, F7M, 32'd7,        32'd0,        32'd0, 32'd0, 32'd7,        1'b0, 0, 1);
        issue(OP, 3'b100, F7M, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 32'h80000000, 1'b0, 0, 1);
        issue(OP, 3'b110, F7M, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0,        1'b0, 0, 1);
        drain();

        issue(OP, 3'b100, F7M, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFD, 1'b0, 33, 1);
        saw = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (in_ready) saw = 1'b1;
        end
        chk("div_in_ready_low", {31'd0, saw}, 32'd0);
        drain();
        issue(OP, 3'b110, F7M, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 33, 1);
        drain();
        issue(OP, 3'b101, F7M, 32'd100, 32'd7, 32'd0, 32'd0, 32'd14, 1'b0, 33, 1);
        drain();
        issue(OP, 3'b111, F7M, 32'd100, 32'd7, 32'd0, 32'd0, 32'd2, 1'b0, 33, 1);
        drain();

        // flush on cycle 10 of a divide
        issue(OP, 3'b100, F7M, 32'd1000, 32'd3, 32'd0, 32'd0, 32'd0, 1'b0, 0, 0);
        repeat (9) @(negedge clk);
        chk("div_busy_mid", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("div_flush_busy", {31'd0, busy}, 32'd0);
        chk("div_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("div_flush_ready", {31'd0, in_ready}, 32'd1);

        // reset in the middle of a divide
        issue(OP, 3'b100, F7M, 32'd1000, 32'd3, 32'd0, 32'd0, 32'd0, 1'b0, 0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("div_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("div_rst_no_result", {31'd0, out_valid}, 32'd0);
`else
        // without the M extension these are unknown single-cycle ops
        issue(OP, 3'b000, F7M, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 0, 1);
        issue(OP, 3'b100, F7M, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'd0, 1'b0, 0, 1);
        @(negedge clk);
        chk("nomd_busy", {31'd0, busy}, 32'd0);
        drain();
`endif

        drain();
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
